// File: rtl/irrigation_pkg.sv
// Shared types and helpers for the irrigation cycle controller.
// Contents: FSM state enum, valve mode encoding, BCD geometry constants,
// and a constant function that validates a 3-digit BCD preset.
package irrigation_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_DIGITS  = 3;
  localparam int unsigned BCD_W       = BCD_DIGIT_W * BCD_DIGITS;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_e;

  typedef enum logic {
    MODE_DRIP      = 1'b0,
    MODE_SPRINKLER = 1'b1
  } mode_e;

  // True when every nibble of the value is a decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_down_counter_3d.sv
// Three-digit BCD down counter with load, clear and saturate-at-zero.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   load_i        : load load_value_i (lower priority than clear_i)
//   load_value_i  : BCD value to load
//   dec_en_i      : decrement by one (ignored when already zero)
//   clear_i       : force count to zero
//   count_o       : registered BCD count
//   zero_c_o      : combinational flag, count_o == 000
module bcd_down_counter_3d
  import irrigation_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_value_i,
  input  logic             dec_en_i,
  input  logic             clear_i,
  output logic [BCD_W-1:0] count_o,
  output logic             zero_c_o
);

  logic [BCD_W-1:0] count_q;
  logic [BCD_W-1:0] count_d;
  logic [BCD_W-1:0] dec_val;
  logic             borrow;

  // Borrow chain: a zero digit wraps to 9 and passes the borrow upward.
  always_comb begin
    dec_val = count_q;
    borrow  = 1'b1;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (borrow) begin
        if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0) begin
          dec_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_DIGIT_W'(9);
        end else begin
          dec_val[i*BCD_DIGIT_W +: BCD_DIGIT_W] =
            count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] - BCD_DIGIT_W'(1);
          borrow = 1'b0;
        end
      end
    end
  end

  assign zero_c_o = (count_q == '0);

  // Next count: clear > load > decrement; zero never wraps.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (dec_en_i && !zero_c_o) begin
      count_d = dec_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/irrigation_cycle_controller.sv
// Sequences one drip or sprinkler watering cycle over a shared BCD seconds
// countdown and drives the matching valve.
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   tick                     : one-cycle seconds strobe
//   req_drip, req_sprinkler  : level cycle requests (drip wins a tie)
//   pause                    : freeze countdown, close valves
//   abort                    : end the running cycle immediately
//   count_bcd                : remaining seconds, {hundreds, tens, units}
//   valve_drip/sprinkler     : valve open
//   busy                     : cycle in progress (LOAD..DONE)
//   done, aborted            : one-cycle completion / abort pulses
module irrigation_cycle_controller
  import irrigation_pkg::*;
#(
  parameter logic [BCD_W-1:0] DRIP_PRESET      = 12'h300,
  parameter logic [BCD_W-1:0] SPRINKLER_PRESET = 12'h150
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             req_drip,
  input  logic             req_sprinkler,
  input  logic             pause,
  input  logic             abort,
  output logic [BCD_W-1:0] count_bcd,
  output logic             valve_drip,
  output logic             valve_sprinkler,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  localparam bit PRESETS_OK = bcd_valid(DRIP_PRESET) && bcd_valid(SPRINKLER_PRESET);

  generate
    if (!PRESETS_OK) begin : g_bad_preset
      $error("irrigation_cycle_controller: preset contains a non-BCD nibble");
    end
  endgenerate

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             cnt_load, cnt_dec, cnt_clear, cnt_zero;
  logic [BCD_W-1:0] cnt_load_value;
  logic             valve_drip_q, valve_drip_d;
  logic             valve_sprinkler_q, valve_sprinkler_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  bcd_down_counter_3d u_counter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (cnt_load),
    .load_value_i (cnt_load_value),
    .dec_en_i     (cnt_dec),
    .clear_i      (cnt_clear),
    .count_o      (count_bcd),
    .zero_c_o     (cnt_zero)
  );

  // Next-state, counter control and next-output logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clear = 1'b0;
    aborted_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!abort && (req_drip || req_sprinkler)) begin
          mode_d   = req_drip ? MODE_DRIP : MODE_SPRINKLER;
          cnt_load = 1'b1;
          state_d  = S_LOAD;
        end
      end
      // Count already holds the preset here, so zero means a zero preset.
      S_LOAD: begin
        state_d = cnt_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_clear = 1'b1;
          aborted_d = 1'b1;
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (tick) begin
          cnt_dec = 1'b1;
          if (count_bcd == BCD_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_HOLD: begin
        if (abort) begin
          state_d   = S_IDLE;
          cnt_clear = 1'b1;
          aborted_d = 1'b1;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        cnt_clear = 1'b1;
      end
      default: begin
        state_d   = S_IDLE;
        cnt_clear = 1'b1;
      end
    endcase

    cnt_load_value    = (mode_d == MODE_DRIP) ? DRIP_PRESET : SPRINKLER_PRESET;
    // Outputs are decoded from the next state so they register in step with it.
    valve_drip_d      = (state_d == S_RUN) && (mode_d == MODE_DRIP);
    valve_sprinkler_d = (state_d == S_RUN) && (mode_d == MODE_SPRINKLER);
    busy_d            = (state_d != S_IDLE);
    done_d            = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      mode_q            <= MODE_DRIP;
      valve_drip_q      <= 1'b0;
      valve_sprinkler_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      aborted_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      mode_q            <= mode_d;
      valve_drip_q      <= valve_drip_d;
      valve_sprinkler_q <= valve_sprinkler_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      aborted_q         <= aborted_d;
    end
  end

  assign valve_drip      = valve_drip_q;
  assign valve_sprinkler = valve_sprinkler_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;

endmodule

// File: tb/tb_irrigation_cycle_controller.sv
// Directed bench: unit A (drip 012, sprinkler 000) covers the drip cycle,
// tie-break, zero preset, pause and abort; unit B (drip 101, sprinkler 050)
// covers the borrow chain and a mid-run reset.
module tb_irrigation_cycle_controller;

  logic clk;
  logic a_rst_n, a_tick, a_req_d, a_req_s, a_pause, a_abort;
  logic b_rst_n, b_tick, b_req_d, b_req_s, b_pause, b_abort;
  logic [11:0] a_cnt, b_cnt;
  logic a_vd, a_vs, a_busy, a_done, a_ab;
  logic b_vd, b_vs, b_busy, b_done, b_ab;

  int n_chk = 0;
  int n_bad = 0;
  logic [11:0] exp_cnt [12];

  irrigation_cycle_controller #(.DRIP_PRESET(12'h012), .SPRINKLER_PRESET(12'h000)) u_a (
    .clk(clk), .rst_n(a_rst_n), .tick(a_tick), .req_drip(a_req_d),
    .req_sprinkler(a_req_s), .pause(a_pause), .abort(a_abort),
    .count_bcd(a_cnt), .valve_drip(a_vd), .valve_sprinkler(a_vs),
    .busy(a_busy), .done(a_done), .aborted(a_ab)
  );

  irrigation_cycle_controller #(.DRIP_PRESET(12'h101), .SPRINKLER_PRESET(12'h050)) u_b (
    .clk(clk), .rst_n(b_rst_n), .tick(b_tick), .req_drip(b_req_d),
    .req_sprinkler(b_req_s), .pause(b_pause), .abort(b_abort),
    .count_bcd(b_cnt), .valve_drip(b_vd), .valve_sprinkler(b_vs),
    .busy(b_busy), .done(b_done), .aborted(b_ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // n single-cycle ticks separated by an idle cycle; returns right after the last tick edge.
  task automatic pulse_ticks(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel_b) b_tick = 1'b1; else a_tick = 1'b1;
      step();
      b_tick = 1'b0;
      a_tick = 1'b0;
      if (i != n - 1) step();
    end
  endtask

  initial begin
    exp_cnt = '{12'h011, 12'h010, 12'h009, 12'h008, 12'h007, 12'h006,
                12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};
    a_rst_n = 0; a_tick = 0; a_req_d = 0; a_req_s = 0; a_pause = 0; a_abort = 0;
    b_rst_n = 0; b_tick = 0; b_req_d = 0; b_req_s = 0; b_pause = 0; b_abort = 0;
    step(); step();
    chk_eq("rst_cnt", a_cnt, 12'h000);
    chk_eq("rst_outs", {a_vd, a_vs, a_busy, a_done, a_ab}, 5'b0);
    chk_eq("rst_b_outs", {b_vd, b_vs, b_busy, b_done, b_ab}, 5'b0);
    a_rst_n = 1; b_rst_n = 1;
    step();

    // Drip cycle, preset 012.
    a_req_d = 1;
    step();
    chk_eq("drip_load_busy", a_busy, 1);
    chk_eq("drip_load_cnt", a_cnt, 12'h012);
    chk_eq("drip_load_valve", a_vd, 0);
    a_req_d = 0;
    step();
    chk_eq("drip_run_valves", {a_vd, a_vs}, 2'b10);
    chk_eq("drip_run_cnt", a_cnt, 12'h012);
    for (int k = 0; k < 12; k++) begin
      a_tick = 1;
      step();
      a_tick = 0;
      chk_eq($sformatf("drip_cnt%0d", k), a_cnt, exp_cnt[k]);
      if (k != 11) begin
        chk_eq($sformatf("drip_valve%0d", k), {a_vd, a_done}, 2'b10);
        step();
      end
    end
    chk_eq("drip_done", {a_done, a_vd, a_busy}, 3'b101);
    step();
    chk_eq("drip_idle", {a_done, a_busy, a_vd}, 3'b000);
    chk_eq("drip_idle_cnt", a_cnt, 12'h000);

    // Both requests: drip wins; sprinkler (zero preset) follows while still requested.
    a_req_d = 1; a_req_s = 1;
    step();
    chk_eq("both_load_cnt", a_cnt, 12'h012);
    a_req_d = 0;
    step();
    chk_eq("both_run_valves", {a_vd, a_vs}, 2'b10);
    pulse_ticks(1'b0, 12);
    chk_eq("both_drip_done", {a_done, a_vd, a_vs}, 3'b100);
    step();
    chk_eq("both_idle_gap", a_busy, 0);
    step();
    chk_eq("zero_load", {a_busy, a_vs, a_done}, 3'b100);
    chk_eq("zero_load_cnt", a_cnt, 12'h000);
    a_req_s = 0;
    step();
    chk_eq("zero_done", {a_done, a_vs, a_busy}, 3'b101);
    step();
    chk_eq("zero_idle", {a_done, a_busy, a_vs}, 3'b000);

    // Request during abort in IDLE is ignored.
    a_abort = 1; a_req_d = 1;
    step();
    chk_eq("idle_abort_ign", a_busy, 0);
    a_abort = 0; a_req_d = 0;
    step();

    // Pause with ticks, then abort together with a tick at 007.
    a_req_d = 1;
    step();
    a_req_d = 0;
    step();
    pulse_ticks(1'b0, 3);
    chk_eq("pre_pause_cnt", a_cnt, 12'h009);
    a_pause = 1;
    step();
    chk_eq("hold_valves", {a_vd, a_vs, a_busy}, 3'b001);
    for (int k = 0; k < 5; k++) begin
      a_tick = 1;
      step();
      chk_eq($sformatf("hold_cnt%0d", k), a_cnt, 12'h009);
      chk_eq($sformatf("hold_valve%0d", k), a_vd, 0);
    end
    a_tick = 0; a_pause = 0;
    step();
    chk_eq("resume_valve", a_vd, 1);
    chk_eq("resume_cnt", a_cnt, 12'h009);
    pulse_ticks(1'b0, 2);
    chk_eq("pre_abort_cnt", a_cnt, 12'h007);
    a_abort = 1; a_tick = 1;
    step();
    a_abort = 0; a_tick = 0;
    chk_eq("abort_cnt", a_cnt, 12'h000);
    chk_eq("abort_outs", {a_ab, a_done, a_vd, a_busy}, 4'b1000);
    step();
    chk_eq("abort_pulse_end", {a_ab, a_done}, 2'b00);

    // Unit B: borrow chain 101 -> 100 -> 099.
    b_req_d = 1;
    step();
    b_req_d = 0;
    step();
    chk_eq("borrow_start", b_cnt, 12'h101);
    pulse_ticks(1'b1, 1);
    chk_eq("borrow_100", b_cnt, 12'h100);
    step();
    pulse_ticks(1'b1, 1);
    chk_eq("borrow_099", b_cnt, 12'h099);
    b_abort = 1;
    step();
    b_abort = 0;
    chk_eq("b_abort_idle", {b_busy, b_ab}, 2'b01);
    step();

    // Unit B: reset mid-run at 045.
    b_req_s = 1;
    step();
    b_req_s = 0;
    step();
    chk_eq("spr_run_valves", {b_vd, b_vs}, 2'b01);
    pulse_ticks(1'b1, 5);
    chk_eq("spr_cnt045", b_cnt, 12'h045);
    chk_eq("spr_valve045", b_vs, 1);
    b_rst_n = 0;
    step();
    chk_eq("midrst_cnt", b_cnt, 12'h000);
    chk_eq("midrst_outs", {b_vd, b_vs, b_busy, b_done, b_ab}, 5'b0);
    b_rst_n = 1;
    step();
    chk_eq("postrst_outs", {b_busy, b_done, b_ab, b_vs}, 4'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
